// File: rtl/ascon_pkg.sv
// Shared definitions for the Ascon core arbiter.
//   RATE_W_DEF  : default data block width in bits
//   arb_state_t : arbiter FSM state encoding
package ascon_pkg;

   localparam int RATE_W_DEF = 64;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_START   = 2'd1,
      ST_RUN     = 2'd2,
      ST_RELEASE = 2'd3
   } arb_state_t;

endpackage

// File: rtl/ascon_rr_pick.sv
// Combinational round-robin picker.
// Scans requesters starting at (last_gnt + 1) mod N_REQ and returns the first
// one found as a one-hot winner.
//   req      : per-requester request vector
//   last_gnt : index of the most recently served requester
//   winner   : one-hot winner, zero when no request is pending
//   valid    : high when any request is pending
module ascon_rr_pick
   import ascon_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] last_gnt,
   output logic [N_REQ-1:0] winner,
   output logic             valid
);

   logic [IDX_W:0]   sum;
   logic [IDX_W-1:0] idx;

   always_comb begin
      winner = '0;
      valid  = 1'b0;
      sum    = '0;
      idx    = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         // last_gnt < N_REQ and i <= N_REQ, so one subtraction gives the modulo
         sum = {1'b0, last_gnt} + (IDX_W+1)'(i);
         if (sum >= (IDX_W+1)'(N_REQ)) begin
            sum = sum - (IDX_W+1)'(N_REQ);
         end
         idx = sum[IDX_W-1:0];
         if (!valid && req[idx]) begin
            winner[idx] = 1'b1;
            valid       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ascon_arb.sv
// Arbiter sharing one Ascon core among N_REQ requesters.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no grant; pick round-robin winner when core is ready
// ST_START   | grant held, core_start_o pulses for this one cycle
// ST_RUN     | core strobes/data routed to and from the granted requester
// ST_RELEASE | done_o pulses to the granted requester, grant drops next
//
// Ports:
//   clk_i, rst_i                     clock, synchronous active-high reset
//   req_i / gnt_o                    per-requester level request / one-hot grant
//   data_i, data_valid_i             per-requester data blocks and valids
//   data_req_o, ct_valid_o,
//   tag_valid_o, done_o              per-requester strobes (granted one only)
//   busy_o                           a grant is held
//   core_*_i / core_*_o              Ascon core side handshake and data
module ascon_arb
   import ascon_pkg::*;
#(
   parameter int N_REQ  = 2,
   parameter int RATE_W = RATE_W_DEF
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [N_REQ-1:0]        req_i,
   output logic [N_REQ-1:0]        gnt_o,
   input  logic [N_REQ*RATE_W-1:0] data_i,
   input  logic [N_REQ-1:0]        data_valid_i,
   output logic [N_REQ-1:0]        data_req_o,
   output logic [N_REQ-1:0]        ct_valid_o,
   output logic [N_REQ-1:0]        tag_valid_o,
   output logic [N_REQ-1:0]        done_o,
   output logic                    busy_o,
   input  logic                    core_ready_i,
   input  logic                    core_data_req_i,
   input  logic                    core_ct_valid_i,
   input  logic                    core_tag_valid_i,
   output logic                    core_start_o,
   output logic                    core_data_valid_o,
   output logic [RATE_W-1:0]       core_data_o
);

   localparam int IDX_W = $clog2(N_REQ);

   arb_state_t       state_q, state_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [IDX_W-1:0] last_gnt_q, last_gnt_d;
   logic [IDX_W-1:0] gnt_idx;
   logic [N_REQ-1:0] pick_winner;
   logic             pick_valid;

   ascon_rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req      (req_i),
      .last_gnt (last_gnt_q),
      .winner   (pick_winner),
      .valid    (pick_valid)
   );

   always_comb begin
      gnt_idx = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (gnt_q[k]) gnt_idx = IDX_W'(k);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         gnt_q      <= '0;
         // last served = N_REQ-1 so requester 0 wins the first round
         last_gnt_q <= IDX_W'(N_REQ - 1);
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         last_gnt_q <= last_gnt_d;
      end
   end

   always_comb begin
      state_d           = state_q;
      gnt_d             = gnt_q;
      last_gnt_d        = last_gnt_q;
      core_start_o      = 1'b0;
      core_data_valid_o = 1'b0;
      core_data_o       = '0;
      data_req_o        = '0;
      ct_valid_o        = '0;
      tag_valid_o       = '0;
      done_o            = '0;

      case (state_q)
         ST_IDLE: begin
            if (pick_valid && core_ready_i) begin
               gnt_d   = pick_winner;
               state_d = ST_START;
            end
         end
         ST_START: begin
            core_start_o = 1'b1;
            state_d      = ST_RUN;
         end
         ST_RUN: begin
            for (int k = 0; k < N_REQ; k++) begin
               if (gnt_q[k]) core_data_o = data_i[k*RATE_W +: RATE_W];
            end
            core_data_valid_o = |(data_valid_i & gnt_q);
            data_req_o        = gnt_q & {N_REQ{core_data_req_i}};
            ct_valid_o        = gnt_q & {N_REQ{core_ct_valid_i}};
            tag_valid_o       = gnt_q & {N_REQ{core_tag_valid_i}};
            if (core_tag_valid_i) state_d = ST_RELEASE;
         end
         ST_RELEASE: begin
            done_o     = gnt_q;
            gnt_d      = '0;
            last_gnt_d = gnt_idx;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign gnt_o  = gnt_q;
   assign busy_o = |gnt_q;

endmodule

// File: tb/tb_ascon_arb.sv
module tb_ascon_arb;

   localparam int N_REQ  = 2;
   localparam int RATE_W = 64;

   logic                    clk_i;
   logic                    rst_i;
   logic [N_REQ-1:0]        req_i;
   logic [N_REQ-1:0]        gnt_o;
   logic [N_REQ*RATE_W-1:0] data_i;
   logic [N_REQ-1:0]        data_valid_i;
   logic [N_REQ-1:0]        data_req_o;
   logic [N_REQ-1:0]        ct_valid_o;
   logic [N_REQ-1:0]        tag_valid_o;
   logic [N_REQ-1:0]        done_o;
   logic                    busy_o;
   logic                    core_ready_i;
   logic                    core_data_req_i;
   logic                    core_ct_valid_i;
   logic                    core_tag_valid_i;
   logic                    core_start_o;
   logic                    core_data_valid_o;
   logic [RATE_W-1:0]       core_data_o;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [63:0] DATA0 = 64'hA5A5_0000_1111_2222;
   localparam logic [63:0] DATA1 = 64'h5A5A_3333_4444_5555;

   ascon_arb #(
      .N_REQ  (N_REQ),
      .RATE_W (RATE_W)
   ) dut (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .req_i             (req_i),
      .gnt_o             (gnt_o),
      .data_i            (data_i),
      .data_valid_i      (data_valid_i),
      .data_req_o        (data_req_o),
      .ct_valid_o        (ct_valid_o),
      .tag_valid_o       (tag_valid_o),
      .done_o            (done_o),
      .busy_o            (busy_o),
      .core_ready_i      (core_ready_i),
      .core_data_req_i   (core_data_req_i),
      .core_ct_valid_i   (core_ct_valid_i),
      .core_tag_valid_i  (core_tag_valid_i),
      .core_start_o      (core_start_o),
      .core_data_valid_o (core_data_valid_o),
      .core_data_o       (core_data_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Waits (bounded) for a grant, checks it, then runs a minimal operation.
   task automatic do_op(input string tag, input logic [N_REQ-1:0] exp);
      bit found;
      found = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (gnt_o != '0) begin
            found = 1'b1;
            break;
         end
      end
      check_eq({tag, "_granted"}, 64'(found), 64'd1);
      check_eq({tag, "_gnt"}, 64'(gnt_o), 64'(exp));
      tick();
      core_tag_valid_i = 1'b1;
      tick();
      core_tag_valid_i = 1'b0;
      check_eq({tag, "_done"}, 64'(done_o), 64'(exp));
      tick();
   endtask

   initial begin
      logic [N_REQ-1:0] seen_gnt;
      logic             seen_start;

      rst_i            = 1'b1;
      req_i            = '0;
      data_i           = {DATA1, DATA0};
      data_valid_i     = '0;
      core_ready_i     = 1'b0;
      core_data_req_i  = 1'b0;
      core_ct_valid_i  = 1'b0;
      core_tag_valid_i = 1'b0;
      tick();
      tick();
      rst_i = 1'b0;
      check_eq("rst_gnt", 64'(gnt_o), 64'd0);
      check_eq("rst_busy", 64'(busy_o), 64'd0);
      check_eq("rst_start", 64'(core_start_o), 64'd0);
      check_eq("rst_data", core_data_o, 64'd0);

      // single request, full handshake with latency checks
      req_i        = 2'b01;
      core_ready_i = 1'b1;
      tick();
      check_eq("single_gnt_c1", 64'(gnt_o), 64'h1);
      check_eq("single_start_c1", 64'(core_start_o), 64'd1);
      check_eq("single_busy_c1", 64'(busy_o), 64'd1);
      check_eq("single_data_start", core_data_o, 64'd0);
      tick();
      check_eq("single_start_c2", 64'(core_start_o), 64'd0);
      data_valid_i    = 2'b01;
      core_data_req_i = 1'b1;
      #1;
      check_eq("single_data_req", 64'(data_req_o), 64'h1);
      check_eq("single_core_data", core_data_o, DATA0);
      check_eq("single_core_dv", 64'(core_data_valid_o), 64'd1);
      core_tag_valid_i = 1'b1;
      #1;
      check_eq("single_tag_valid", 64'(tag_valid_o), 64'h1);
      check_eq("single_no_early_done", 64'(done_o), 64'd0);
      tick();
      core_tag_valid_i = 1'b0;
      core_data_req_i  = 1'b0;
      data_valid_i     = '0;
      check_eq("single_done", 64'(done_o), 64'h1);
      check_eq("single_gnt_release", 64'(gnt_o), 64'h1);
      check_eq("single_data_release", core_data_o, 64'd0);
      req_i = '0;
      tick();
      check_eq("single_gnt_cleared", 64'(gnt_o), 64'd0);
      check_eq("single_done_once", 64'(done_o), 64'd0);
      check_eq("single_busy_cleared", 64'(busy_o), 64'd0);

      // both requesting from reset: strict alternation
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      req_i = 2'b11;
      do_op("rr0", 2'b01);
      do_op("rr1", 2'b10);
      do_op("rr2", 2'b01);
      do_op("rr3", 2'b10);

      // requester 1 granted, both present data: only requester 1 is routed
      req_i = 2'b10;
      tick();
      check_eq("route_gnt", 64'(gnt_o), 64'h2);
      tick();
      data_valid_i    = 2'b11;
      core_data_req_i = 1'b1;
      core_ct_valid_i = 1'b1;
      #1;
      check_eq("route_data", core_data_o, DATA1);
      check_eq("route_dv", 64'(core_data_valid_o), 64'd1);
      check_eq("route_data_req", 64'(data_req_o), 64'h2);
      check_eq("route_ct_valid", 64'(ct_valid_o), 64'h2);
      data_valid_i = 2'b01;
      #1;
      check_eq("route_dv_ignored", 64'(core_data_valid_o), 64'd0);
      core_tag_valid_i = 1'b1;
      #1;
      check_eq("route_tag_valid", 64'(tag_valid_o), 64'h2);
      tick();
      core_tag_valid_i = 1'b0;
      core_data_req_i  = 1'b0;
      core_ct_valid_i  = 1'b0;
      data_valid_i     = '0;
      check_eq("route_done", 64'(done_o), 64'h2);
      req_i = '0;
      tick();

      // core not ready blocks granting
      core_ready_i = 1'b0;
      req_i        = 2'b01;
      seen_gnt     = '0;
      seen_start   = 1'b0;
      for (int c = 0; c < 20; c++) begin
         tick();
         seen_gnt   = seen_gnt | gnt_o;
         seen_start = seen_start | core_start_o;
      end
      check_eq("notready_gnt", 64'(seen_gnt), 64'd0);
      check_eq("notready_start", 64'(seen_start), 64'd0);
      core_ready_i = 1'b1;
      tick();
      check_eq("ready_gnt", 64'(gnt_o), 64'h1);
      tick();

      // reset in RUN abandons the grant
      rst_i = 1'b1;
      tick();
      check_eq("midrst_gnt", 64'(gnt_o), 64'd0);
      check_eq("midrst_busy", 64'(busy_o), 64'd0);
      check_eq("midrst_done", 64'(done_o), 64'd0);
      rst_i = 1'b0;
      req_i = 2'b10;
      tick();
      check_eq("postrst_gnt", 64'(gnt_o), 64'h2);
      tick();

      // request dropped mid-RUN: grant held, done still pulses
      req_i = '0;
      tick();
      tick();
      check_eq("drop_gnt_held", 64'(gnt_o), 64'h2);
      core_tag_valid_i = 1'b1;
      tick();
      core_tag_valid_i = 1'b0;
      check_eq("drop_done", 64'(done_o), 64'h2);
      tick();
      tick();
      check_eq("drop_idle_gnt", 64'(gnt_o), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
